fft_sequencer: RTL
==================

// Module: fft_sequencer
// PURPOSE
// Control end of the 512-point FFT address generation interface: drives the
// load / processing / done phase flags and the fft_level, butterfly_iter,
// load_address and out_address indices into the AGU. Sequences one frame:
// sample load, 9 butterfly levels and result unload, with handshakes on the
// input and output sides. Sits between the sample source/reader and the
// AGU + dual-bank RAM + butterfly datapath.
// PARAMETERS
// N_LOG2    9   log2 of FFT size. Gives 9 levels and 256 butterflies per level.
// PIPE_LAT  2   cycles from butterfly address issue to write-back (>=1)
// PORTS
// clk             in   1  system clock
// reset           in   1  synchronous, active-high reset
// start           in   1  begin a new frame; honoured only in IDLE
// sample_valid    in   1  input sample present on the datapath
// sample_ready    out  1  sequencer accepts a sample this cycle
// out_ready       in   1  reader has taken the result at out_address
// out_valid       out  1  out_address is valid for reading
// load            out  1  load phase flag to the AGU
// processing      out  1  butterfly phase flag to the AGU
// done            out  1  unload phase flag to the AGU
// fft_level       out  9  current level, 0..8
// butterfly_iter  out  9  current butterfly, 0..255; bit 8 is always 0
// load_address    out  9  natural-order input index (the AGU bit-reverses it)
// out_address     out  9  natural-order output index
// write_en        out  1  RAM write strobe (load accept or butterfly write-back)
// rd_bank         out  1  bank holding the source data = fft_level[0]
// frame_done      out  1  one-cycle pulse on the final output transfer
// BEHAVIOUR
// - Reset (sync): state IDLE; all counters 0; every 1-bit output 0; delay line cleared.
// - Reset mid-frame: aborts at the next edge. No write_en pulse from in-flight
//   butterflies is emitted after reset.
// - IDLE: all flags 0. start=1 -> LOAD on the next cycle. start in any other state is ignored.
// - LOAD: load=1, sample_ready=1. accept = sample_valid & sample_ready.
//   write_en = accept (combinational). On accept, load_address increments.
//   On an accept with load_address==511, go to PROC and clear load_address to 0.
// - PROC: processing=1. Issue one butterfly per cycle. butterfly_iter counts 0..255.
//   - issue_valid enters the PIPE_LAT delay line. write_en = delayed issue_valid.
//   - The butterfly datapath delays its own write addresses by the same amount.
//   - At iter 255, go to LVL_DRAIN and clear butterfly_iter.
// - LVL_DRAIN: processing=1, no issue. Wait exactly PIPE_LAT cycles so the
//   last write-back lands (prevents a read-after-write hazard across levels).
//   - If fft_level<8: fft_level+1, then back to PROC.
//   - If fft_level==8: go to DONE and hold fft_level at 8.
// - rd_bank toggles with the level (ping-pong). Writes go to the other bank.
//   After level 8, results are in bank 1.
// - DONE: done=1, out_valid=1. On out_valid & out_ready, out_address increments.
//   - Transfer with out_address==511: frame_done=1 that cycle; next state IDLE;
//     out_address and fft_level clear.
//   - out_ready low: hold out_address, with no timeout.
// - Counter arithmetic: all counters are N_LOG2 bits and unsigned. Wrap never
//   occurs because terminal-count checks precede every increment.
// - Timing: at most one of load/processing/done is high. With continuous
//   handshakes, LOAD is 512 cycles, PROC+DRAIN is 9*(256+PIPE_LAT) cycles,
//   DONE is 512 cycles.
// STRUCTURE
// - Package fft_pkg: N_LOG2, N=1<<N_LOG2, N_BF=N/2, N_LEVELS=N_LOG2, and the
//   typedef enum logic[2:0] seq_state_t {IDLE,LOAD,PROC,LVL_DRAIN,DONE}.
// - Sub-module fft_wb_delay: PIPE_LAT-deep shift register with sync clear.
//   Carries issue_valid and produces the write-back write_en.
// - Top level: state register, next-state logic and the four counters.
// TESTING
// 1. Reset mid-PROC at level 3, iter 100 -> next cycle IDLE, all outputs 0,
//    no write_en pulse in the following 5 cycles.
// 2. start, sample_valid held high 512 cycles -> 512 write_en pulses, load_address
//    0..511, PROC entered on cycle 513.
// 3. sample_valid toggled 1/0 -> load_address advances only on accept;
//    LOAD lasts 1024 cycles.
// 4. PROC, PIPE_LAT=2 -> fft_level 0..8, each level 258 cycles, 256 write-back
//    pulses per level, 2322 total cycles, rd_bank alternating 0,1,0,...
// 5. DONE with out_ready=1 every third cycle -> out_address steps every third
//    cycle; frame_done after 1536 cycles; then IDLE.
// 6. start asserted during LOAD/PROC/DONE -> no effect. start in the cycle after
//    frame_done -> new frame, load_address 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared sizing constants and sequencer state encoding for the 512-point FFT control path.
package fft_pkg;

  localparam int unsigned N_LOG2   = 9;
  localparam int unsigned N        = 1 << N_LOG2;
  localparam int unsigned N_BF     = N / 2;
  localparam int unsigned N_LEVELS = N_LOG2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PROC,
    LVL_DRAIN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/fft_wb_delay.sv
// Write-back delay line: carries butterfly issue_valid forward by PIPE_LAT cycles.
module fft_wb_delay #(
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic issue_valid,
  output logic wb_valid
);

  logic [PIPE_LAT-1:0] stage;

  // Shift register; reset flushes in-flight butterflies so no stray write follows an abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage <= '0;
    end else begin
      stage[0] <= issue_valid;
      for (int i = 1; i < int'(PIPE_LAT); i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign wb_valid = stage[PIPE_LAT-1];

endmodule

// File: rtl/fft_sequencer.sv
// Frame sequencer for the FFT AGU: sample load, 9 butterfly levels with drain, result unload.
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              load,
  output logic              processing,
  output logic              done,
  output logic [N_LOG2-1:0] fft_level,
  output logic [N_LOG2-1:0] butterfly_iter,
  output logic [N_LOG2-1:0] load_address,
  output logic [N_LOG2-1:0] out_address,
  output logic              write_en,
  output logic              rd_bank,
  output logic              frame_done
);

  localparam int unsigned DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [N_LOG2-1:0]  LAST_IDX   = N_LOG2'(N - 1);
  localparam logic [N_LOG2-1:0]  LAST_BF    = N_LOG2'(N_BF - 1);
  localparam logic [N_LOG2-1:0]  LAST_LVL   = N_LOG2'(N_LEVELS - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(PIPE_LAT - 1);

  seq_state_t         state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               issue_valid;
  logic               wb_valid;
  logic               accept;
  logic               transfer;

  // Phase flags and handshakes decode directly from the state register.
  assign load         = (state == LOAD);
  assign processing   = (state == PROC) || (state == LVL_DRAIN);
  assign done         = (state == DONE);
  assign sample_ready = load;
  assign out_valid    = done;
  assign issue_valid  = (state == PROC);
  assign accept       = sample_valid & sample_ready;
  assign transfer     = out_valid & out_ready;
  assign write_en     = accept | wb_valid;
  assign rd_bank      = fft_level[0];
  assign frame_done   = transfer && (out_address == LAST_IDX);

  fft_wb_delay #(
    .PIPE_LAT (PIPE_LAT)
  ) u_wb_delay (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .wb_valid    (wb_valid)
  );

  // State machine and frame counters; terminal checks precede every increment so nothing wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      fft_level      <= '0;
      butterfly_iter <= '0;
      load_address   <= '0;
      out_address    <= '0;
      drain_cnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) state <= LOAD;
        end
        LOAD: begin
          if (accept) begin
            if (load_address == LAST_IDX) begin
              load_address <= '0;
              state        <= PROC;
            end else begin
              load_address <= load_address + N_LOG2'(1);
            end
          end
        end
        PROC: begin
          if (butterfly_iter == LAST_BF) begin
            butterfly_iter <= '0;
            drain_cnt      <= '0;
            state          <= LVL_DRAIN;
          end else begin
            butterfly_iter <= butterfly_iter + N_LOG2'(1);
          end
        end
        LVL_DRAIN: begin
          // Hold off the next level until the last write-back of this one has landed.
          if (drain_cnt == LAST_DRAIN) begin
            drain_cnt <= '0;
            if (fft_level == LAST_LVL) begin
              state <= DONE;
            end else begin
              fft_level <= fft_level + N_LOG2'(1);
              state     <= PROC;
            end
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        DONE: begin
          if (transfer) begin
            if (out_address == LAST_IDX) begin
              out_address <= '0;
              fft_level   <= '0;
              state       <= IDLE;
            end else begin
              out_address <= out_address + N_LOG2'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
